// File: rtl/uart_apb_sequencer.sv
// APB master that round-robins a TX byte stream (THR writes) and an RX byte stream
// (RBR reads) onto one UART APB port, gated by the UART's DMA ready lines.
module uart_apb_sequencer #(
   parameter logic [7:0]  THR_ADDR = 8'h00,
   parameter logic [7:0]  RBR_ADDR = 8'h00,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             tx_start,
   input  logic [CNT_W-1:0] tx_len,
   input  logic             rx_start,
   input  logic [CNT_W-1:0] rx_len,
   input  logic             tx_valid,
   input  logic [7:0]       tx_data,
   output logic             tx_ready,
   output logic             rx_valid,
   output logic [7:0]       rx_data,
   input  logic             rx_ready,
   output logic             PSEL,
   output logic             PENABLE,
   output logic             PWRITE,
   output logic [7:0]       PADDR,
   output logic [7:0]       PWDATA,
   input  logic [7:0]       PRDATA,
   input  logic             PREADY,
   input  logic             PSLVERR,
   input  logic             TXDRDYn,
   input  logic             RXDRDYn,
   output logic             tx_busy,
   output logic             rx_busy,
   output logic             tx_done,
   output logic             rx_done,
   output logic             tx_err,
   output logic             rx_err,
   input  logic             err_clr
);

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e           r_state, w_state_next;
   logic             r_last_tx;
   logic             r_pwrite;
   logic [7:0]       r_paddr, r_pwdata;
   logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;
   logic             r_tx_busy, r_rx_busy;
   logic             r_tx_done, r_rx_done;
   logic             r_tx_err, r_rx_err;
   logic             r_rx_valid;
   logic [7:0]       r_rx_data;

   logic w_tx_elig, w_rx_elig;
   logic w_grant_tx, w_grant_rx;
   logic w_complete, w_tx_ok, w_rx_ok, w_tx_bad, w_rx_bad;

   assign w_tx_elig = r_tx_busy & ~TXDRDYn & tx_valid;
   assign w_rx_elig = r_rx_busy & ~RXDRDYn & ~r_rx_valid;

   always_comb begin
      w_state_next = r_state;
      w_grant_tx   = 1'b0;
      w_grant_rx   = 1'b0;
      unique case (r_state)
         StIdle: begin
            // On a tie the channel that did not win last time goes first.
            if (w_tx_elig && (!w_rx_elig || !r_last_tx)) begin
               w_grant_tx = 1'b1;
            end else if (w_rx_elig) begin
               w_grant_rx = 1'b1;
            end
            if (w_grant_tx || w_grant_rx) begin
               w_state_next = StSetup;
            end
         end
         StSetup:  w_state_next = StAccess;
         StAccess: if (PREADY) w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   // r_last_tx doubles as the owner of the transfer in flight.
   assign w_complete = (r_state == StAccess) & PREADY;
   assign w_tx_ok    = w_complete & ~PSLVERR &  r_last_tx;
   assign w_rx_ok    = w_complete & ~PSLVERR & ~r_last_tx;
   assign w_tx_bad   = w_complete &  PSLVERR &  r_last_tx;
   assign w_rx_bad   = w_complete &  PSLVERR & ~r_last_tx;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state   <= StIdle;
         r_last_tx <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= 8'h00;
         r_pwdata  <= 8'h00;
      end else begin
         r_state <= w_state_next;
         if (w_grant_tx) begin
            r_last_tx <= 1'b1;
            r_pwrite  <= 1'b1;
            r_paddr   <= THR_ADDR;
            r_pwdata  <= tx_data;
         end else if (w_grant_rx) begin
            r_last_tx <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= RBR_ADDR;
            r_pwdata  <= 8'h00;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_tx_cnt  <= '0;
         r_tx_busy <= 1'b0;
         r_tx_done <= 1'b0;
         r_tx_err  <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         if (tx_start && !r_tx_busy) begin
            if (tx_len == '0) begin
               r_tx_done <= 1'b1;
            end else begin
               r_tx_cnt  <= tx_len;
               r_tx_busy <= 1'b1;
            end
         end else if (w_tx_ok) begin
            r_tx_cnt <= r_tx_cnt - CntOne;
            if (r_tx_cnt == CntOne) begin
               r_tx_busy <= 1'b0;
               r_tx_done <= 1'b1;
            end
         end else if (w_tx_bad) begin
            r_tx_cnt  <= '0;
            r_tx_busy <= 1'b0;
         end
         if (err_clr) begin
            r_tx_err <= 1'b0;
         end else if (w_tx_bad) begin
            r_tx_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_rx_cnt   <= '0;
         r_rx_busy  <= 1'b0;
         r_rx_done  <= 1'b0;
         r_rx_err   <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_data  <= 8'h00;
      end else begin
         r_rx_done <= 1'b0;
         if (rx_start && !r_rx_busy) begin
            if (rx_len == '0) begin
               r_rx_done <= 1'b1;
            end else begin
               r_rx_cnt  <= rx_len;
               r_rx_busy <= 1'b1;
            end
         end else if (w_rx_ok) begin
            r_rx_cnt <= r_rx_cnt - CntOne;
            if (r_rx_cnt == CntOne) begin
               r_rx_busy <= 1'b0;
               r_rx_done <= 1'b1;
            end
         end else if (w_rx_bad) begin
            r_rx_cnt  <= '0;
            r_rx_busy <= 1'b0;
         end
         if (err_clr) begin
            r_rx_err <= 1'b0;
         end else if (w_rx_bad) begin
            r_rx_err <= 1'b1;
         end
         if (w_rx_ok) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= PRDATA;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
      end
   end

   assign PSEL     = (r_state != StIdle);
   assign PENABLE  = (r_state == StAccess);
   assign PWRITE   = r_pwrite;
   assign PADDR    = r_paddr;
   assign PWDATA   = r_pwdata;
   assign tx_ready = w_grant_tx;
   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;
   assign tx_busy  = r_tx_busy;
   assign rx_busy  = r_rx_busy;
   assign tx_done  = r_tx_done;
   assign rx_done  = r_rx_done;
   assign tx_err   = r_tx_err;
   assign rx_err   = r_rx_err;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Bench for uart_apb_sequencer: expected APB transfers and RX bytes are queued when
// stimulus is driven and popped as the DUT completes them.
module tb_uart_apb_sequencer;

   localparam logic [7:0] Thr = 8'h20;
   localparam logic [7:0] Rbr = 8'h24;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
   } apb_t;

   logic        PCLK, PRESETn;
   logic        tx_start, rx_start, tx_valid, tx_ready, rx_valid, rx_ready;
   logic [15:0] tx_len, rx_len;
   logic [7:0]  tx_data, rx_data, PADDR, PWDATA, PRDATA;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR, TXDRDYn, RXDRDYn;
   logic        tx_busy, rx_busy, tx_done, rx_done, tx_err, rx_err, err_clr;

   apb_t       exp_q[$];
   logic [7:0] rx_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   uart_apb_sequencer #(.THR_ADDR(Thr), .RBR_ADDR(Rbr), .CNT_W(16)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .tx_start(tx_start), .tx_len(tx_len), .rx_start(rx_start), .rx_len(rx_len),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .TXDRDYn(TXDRDYn), .RXDRDYn(RXDRDYn),
      .tx_busy(tx_busy), .rx_busy(rx_busy), .tx_done(tx_done), .rx_done(rx_done),
      .tx_err(tx_err), .rx_err(rx_err), .err_clr(err_clr)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   function automatic apb_t obs_apb();
      return '{wr: PWRITE, addr: PADDR, data: PWDATA};
   endfunction

   task automatic next_cycle();
      @(posedge PCLK);
      #1;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      #3;
      n_vec++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
         n_err++; $display("FAIL reset_apb_ctrl: got %b required 000", {PSEL, PENABLE, PWRITE}); end
      n_vec++; if ({PADDR, PWDATA} !== 16'h0000) begin
         n_err++; $display("FAIL reset_apb_bus: got %h required 0000", {PADDR, PWDATA}); end
      n_vec++; if ({tx_ready, rx_valid, rx_data} !== 10'h000) begin
         n_err++; $display("FAIL reset_stream: got %h required 000", {tx_ready, rx_valid, rx_data}); end
      n_vec++; if ({tx_busy, rx_busy, tx_done, rx_done, tx_err, rx_err} !== 6'b0) begin
         n_err++; $display("FAIL reset_flags: got %b required 000000",
                           {tx_busy, rx_busy, tx_done, rx_done, tx_err, rx_err}); end
      @(negedge PCLK);
      PRESETn = 1'b1;
      next_cycle();
   endtask

   task automatic test_tx_burst();
      logic [7:0] bytes [3];
      apb_t e;
      int idx, fires, dones, last_fire;
      bytes = '{8'hA5, 8'h5A, 8'h3C};
      idx = 0; fires = 0; dones = 0; last_fire = -10;
      for (int i = 0; i < 3; i++) exp_q.push_back('{wr: 1'b1, addr: Thr, data: bytes[i]});
      TXDRDYn = 1'b0; PREADY = 1'b1; tx_len = 16'd3;
      for (int c = 0; c < 20; c++) begin
         tx_start = (c == 0);
         tx_valid = (idx < 3);
         tx_data  = (idx < 3) ? bytes[idx] : 8'h00;
         #1;
         if (PSEL && PENABLE && PREADY) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++; $display("FAIL tx_burst_extra_xfer: got %h required none", obs_apb());
            end else begin
               e = exp_q.pop_front();
               n_vec++; if (obs_apb() !== e) begin
                  n_err++; $display("FAIL tx_burst_xfer: got %h required %h", obs_apb(), e); end
            end
            if (fires > 0) begin
               n_vec++; if (c - last_fire != 3) begin
                  n_err++; $display("FAIL tx_burst_spacing: got %0d required 3", c - last_fire); end
            end
            last_fire = c; fires++;
         end
         if (tx_done) begin
            dones++;
            n_vec++; if (c != last_fire + 1) begin
               n_err++; $display("FAIL tx_burst_done_time: got %0d required %0d", c, last_fire + 1); end
         end
         if (tx_ready) idx++;
         next_cycle();
      end
      n_vec++; if (fires != 3) begin n_err++; $display("FAIL tx_burst_count: got %0d required 3", fires); end
      n_vec++; if (dones != 1) begin n_err++; $display("FAIL tx_burst_done: got %0d required 1", dones); end
      n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL tx_burst_busy: got %b required 0", tx_busy); end
      tx_valid = 1'b0; TXDRDYn = 1'b1; exp_q.delete();
   endtask

   task automatic test_rx_backpressure();
      apb_t e;
      logic [7:0] b;
      int reads, hold, dones;
      reads = 0; hold = 0; dones = 0;
      for (int i = 0; i < 2; i++) exp_q.push_back('{wr: 1'b0, addr: Rbr, data: 8'h00});
      rx_q.push_back(8'h11); rx_q.push_back(8'h22);
      RXDRDYn = 1'b0; rx_len = 16'd2;
      for (int c = 0; c < 30; c++) begin
         rx_start = (c == 0);
         PRDATA   = (reads == 0) ? 8'h11 : 8'h22;
         rx_ready = (hold >= 5);
         #1;
         if (PSEL && !PENABLE) begin
            n_vec++; if (rx_valid !== 1'b0) begin
               n_err++; $display("FAIL rx_read_while_full: got rx_valid=%b required 0", rx_valid); end
         end
         if (PSEL && PENABLE && PREADY) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++; $display("FAIL rx_extra_xfer: got %h required none", obs_apb());
            end else begin
               e = exp_q.pop_front();
               n_vec++; if (obs_apb() !== e) begin
                  n_err++; $display("FAIL rx_xfer: got %h required %h", obs_apb(), e); end
            end
            reads++;
         end
         if (rx_valid && rx_ready) begin
            if (rx_q.size() == 0) begin
               n_vec++; n_err++; $display("FAIL rx_extra_byte: got %h required none", rx_data);
            end else begin
               b = rx_q.pop_front();
               n_vec++; if (rx_data !== b) begin
                  n_err++; $display("FAIL rx_byte: got %h required %h", rx_data, b); end
            end
         end
         if (rx_valid) hold++;
         if (rx_done) dones++;
         next_cycle();
      end
      n_vec++; if (dones != 1) begin n_err++; $display("FAIL rx_done_count: got %0d required 1", dones); end
      n_vec++; if (rx_q.size() != 0) begin
         n_err++; $display("FAIL rx_bytes_left: got %0d required 0", rx_q.size()); end
      n_vec++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rx_busy_end: got %b required 0", rx_busy); end
      RXDRDYn = 1'b1; rx_ready = 1'b0; exp_q.delete(); rx_q.delete();
   endtask

   task automatic test_arbitration();
      logic [7:0] bytes [2];
      apb_t e;
      int idx, txd, rxd, fires;
      bytes = '{8'hC3, 8'h96};
      idx = 0; txd = 0; rxd = 0; fires = 0;
      exp_q.push_back('{wr: 1'b1, addr: Thr, data: 8'hC3});
      exp_q.push_back('{wr: 1'b0, addr: Rbr, data: 8'h00});
      exp_q.push_back('{wr: 1'b1, addr: Thr, data: 8'h96});
      exp_q.push_back('{wr: 1'b0, addr: Rbr, data: 8'h00});
      TXDRDYn = 1'b0; RXDRDYn = 1'b0; rx_ready = 1'b1; PRDATA = 8'h77;
      tx_len = 16'd2; rx_len = 16'd2;
      for (int c = 0; c < 30; c++) begin
         tx_start = (c == 0); rx_start = (c == 0);
         tx_valid = (idx < 2);
         tx_data  = (idx < 2) ? bytes[idx] : 8'h00;
         #1;
         if (PSEL && PENABLE && PREADY) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++; $display("FAIL arb_extra_xfer: got %h required none", obs_apb());
            end else begin
               e = exp_q.pop_front();
               n_vec++; if (obs_apb() !== e) begin
                  n_err++; $display("FAIL arb_order_%0d: got %h required %h", fires, obs_apb(), e); end
            end
            fires++;
         end
         if (tx_ready) idx++;
         if (tx_done) txd++;
         if (rx_done) rxd++;
         next_cycle();
      end
      n_vec++; if (fires != 4) begin n_err++; $display("FAIL arb_count: got %0d required 4", fires); end
      n_vec++; if ({txd, rxd} != {32'd1, 32'd1}) begin
         n_err++; $display("FAIL arb_done: got tx=%0d rx=%0d required 1 1", txd, rxd); end
      TXDRDYn = 1'b1; RXDRDYn = 1'b1; tx_valid = 1'b0; rx_ready = 1'b0; exp_q.delete();
   endtask

   task automatic test_wait_states();
      apb_t e;
      int idx, waits, grant_c, fires, dones;
      idx = 0; waits = 0; grant_c = -100; fires = 0; dones = 0;
      exp_q.push_back('{wr: 1'b1, addr: Thr, data: 8'h5E});
      TXDRDYn = 1'b0; tx_len = 16'd1; tx_data = 8'h5E;
      for (int c = 0; c < 20; c++) begin
         tx_start = (c == 0);
         tx_valid = (idx < 1);
         PREADY   = !(PENABLE && waits < 4);
         #1;
         if (tx_ready) begin grant_c = c; idx++; end
         if (PENABLE && !PREADY) begin
            waits++;
            n_vec++; if ({PSEL, PENABLE, PADDR, PWDATA} !== {1'b1, 1'b1, Thr, 8'h5E}) begin
               n_err++; $display("FAIL wait_hold: got %h required %h",
                                 {PSEL, PENABLE, PADDR, PWDATA}, {1'b1, 1'b1, Thr, 8'h5E}); end
         end
         if (PSEL && PENABLE && PREADY) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++; $display("FAIL wait_extra_xfer: got %h required none", obs_apb());
            end else begin
               e = exp_q.pop_front();
               n_vec++; if (obs_apb() !== e) begin
                  n_err++; $display("FAIL wait_xfer: got %h required %h", obs_apb(), e); end
            end
            n_vec++; if (c - grant_c + 1 != 7) begin
               n_err++; $display("FAIL wait_duration: got %0d required 7", c - grant_c + 1); end
            fires++;
         end
         if (tx_done) dones++;
         next_cycle();
      end
      n_vec++; if (waits != 4) begin n_err++; $display("FAIL wait_cycles: got %0d required 4", waits); end
      n_vec++; if ({fires, dones} != {32'd1, 32'd1}) begin
         n_err++; $display("FAIL wait_single: got xfers=%0d dones=%0d required 1 1", fires, dones); end
      n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL wait_busy: got %b required 0", tx_busy); end
      PREADY = 1'b1; TXDRDYn = 1'b1; tx_valid = 1'b0; exp_q.delete();
   endtask

   task automatic test_error();
      logic [7:0] bytes [4];
      apb_t e;
      int idx, fires, dones;
      bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
      idx = 0; fires = 0; dones = 0;
      exp_q.push_back('{wr: 1'b1, addr: Thr, data: 8'h01});
      exp_q.push_back('{wr: 1'b1, addr: Thr, data: 8'h02});
      TXDRDYn = 1'b0; tx_len = 16'd4;
      for (int c = 0; c < 25; c++) begin
         tx_start = (c == 0);
         tx_valid = (idx < 4);
         tx_data  = (idx < 4) ? bytes[idx] : 8'h00;
         PSLVERR  = (fires == 1);
         #1;
         if (PSEL && PENABLE && PREADY) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++; $display("FAIL err_write_after_abort: got %h required none", obs_apb());
            end else begin
               e = exp_q.pop_front();
               n_vec++; if (obs_apb() !== e) begin
                  n_err++; $display("FAIL err_xfer: got %h required %h", obs_apb(), e); end
            end
            fires++;
         end
         if (tx_ready) idx++;
         if (tx_done) dones++;
         next_cycle();
      end
      PSLVERR = 1'b0;
      n_vec++; if ({tx_err, tx_busy, rx_err} !== 3'b100) begin
         n_err++; $display("FAIL err_flags: got err/busy/rx_err=%b required 100", {tx_err, tx_busy, rx_err}); end
      n_vec++; if (dones != 0) begin n_err++; $display("FAIL err_done: got %0d required 0", dones); end
      n_vec++; if (fires != 2) begin n_err++; $display("FAIL err_xfer_count: got %0d required 2", fires); end
      err_clr = 1'b1;
      next_cycle();
      err_clr = 1'b0;
      #1;
      n_vec++; if (tx_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b required 0", tx_err); end
      next_cycle();
      TXDRDYn = 1'b1; tx_valid = 1'b0; exp_q.delete();
   endtask

   task automatic test_zero_len();
      int psel_cnt, busy_cnt;
      psel_cnt = 0; busy_cnt = 0;
      RXDRDYn = 1'b0; rx_len = 16'd0;
      for (int c = 0; c < 6; c++) begin
         rx_start = (c == 0);
         #1;
         n_vec++; if (rx_done !== (c == 1)) begin
            n_err++; $display("FAIL zero_len_done_c%0d: got %b required %b", c, rx_done, (c == 1)); end
         if (PSEL) psel_cnt++;
         if (rx_busy) busy_cnt++;
         next_cycle();
      end
      n_vec++; if ({psel_cnt, busy_cnt} != 64'd0) begin
         n_err++; $display("FAIL zero_len_activity: got psel=%0d busy=%0d required 0 0", psel_cnt, busy_cnt); end
      RXDRDYn = 1'b1;
   endtask

   task automatic test_reset_mid();
      int c;
      int psel_cnt;
      logic reached;
      c = 0; psel_cnt = 0; reached = 1'b0;
      TXDRDYn = 1'b0; tx_len = 16'd2; tx_data = 8'hAA; tx_valid = 1'b1; PREADY = 1'b0;
      while (!reached && c < 10) begin
         tx_start = (c == 0);
         #1;
         if (PENABLE) reached = 1'b1;
         else begin next_cycle(); c++; end
      end
      tx_start = 1'b0;
      n_vec++; if (!reached) begin n_err++; $display("FAIL reset_mid_access: got no ACCESS required ACCESS"); end
      PRESETn = 1'b0;
      #1;
      n_vec++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== 19'h0) begin
         n_err++; $display("FAIL reset_mid_apb: got %h required 0", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}); end
      n_vec++; if ({tx_busy, tx_ready, tx_done, tx_err} !== 4'b0) begin
         n_err++; $display("FAIL reset_mid_flags: got %b required 0000", {tx_busy, tx_ready, tx_done, tx_err}); end
      @(negedge PCLK);
      PRESETn = 1'b1; PREADY = 1'b1;
      next_cycle();
      for (int k = 0; k < 5; k++) begin
         #1;
         if (PSEL) psel_cnt++;
         next_cycle();
      end
      n_vec++; if (psel_cnt != 0) begin
         n_err++; $display("FAIL reset_mid_idle: got %0d PSEL cycles required 0", psel_cnt); end
      TXDRDYn = 1'b1; tx_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tx_start = 1'b0; rx_start = 1'b0; tx_len = '0; rx_len = '0;
      tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
      PRDATA = 8'h00; PREADY = 1'b1; PSLVERR = 1'b0;
      TXDRDYn = 1'b1; RXDRDYn = 1'b1; err_clr = 1'b0;
      test_reset();
      test_tx_burst();
      test_rx_backpressure();
      test_arbitration();
      test_wait_states();
      test_error();
      test_zero_len();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_apb_sequencer.md
# uart_apb_sequencer

APB master sequencer that moves bytes between the system's byte streams and the UART's APB slave register port. It watches the UART DMA handshake lines, TXDRDYn and RXDRDYn. It round-robin arbitrates a TX channel (stream to THR writes) and an RX channel (RBR reads to stream) onto the single APB port. It sits between the DMA/stream fabric and the UART top, replacing CPU-driven polling for bulk transfers.

## Interface
Clock and reset: one clock, PCLK; reset PRESETn is asynchronous, active-low.

Parameters:
- THR_ADDR, 8'h00, APB address of the UART transmit holding register
- RBR_ADDR, 8'h00, APB address of the UART receive buffer register
- CNT_W, 16, width of the transfer length counters

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- tx_start  in  1  one-cycle pulse that launches a TX transfer of tx_len bytes
- tx_len  in  CNT_W  TX byte count, sampled on tx_start
- rx_start  in  1  one-cycle pulse that launches an RX transfer of rx_len bytes
- rx_len  in  CNT_W  RX byte count, sampled on rx_start
- tx_valid  in  1  source byte available
- tx_data  in  8  source byte
- tx_ready  out  1  source byte consumed this cycle
- rx_valid  out  1  received byte held in the output buffer
- rx_data  out  8  received byte
- rx_ready  in  1  sink accepts rx_data
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR  out  8  APB address
- PWDATA  out  8  APB write data
- PRDATA  in  8  APB read data
- PREADY  in  1  APB wait control
- PSLVERR  in  1  APB error response
- TXDRDYn  in  1  low = UART can accept a TX byte
- RXDRDYn  in  1  low = UART holds an RX byte
- tx_busy, rx_busy  out  1 each  channel active
- tx_done, rx_done  out  1 each  one-cycle pulse on normal completion
- tx_err, rx_err  out  1 each  sticky; set on PSLVERR for that channel
- err_clr  in  1  clears both error flags

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- Eligibility is evaluated in IDLE only:
  - TX eligible when tx_busy & !TXDRDYn & tx_valid.
  - RX eligible when rx_busy & !RXDRDYn & !rx_valid.
- Arbitration: a single eligible channel wins. If both are eligible, the channel that did not win last time wins. last_grant resets to RX, so TX wins the first tie.
- TX grant:
  - tx_ready is high for exactly the IDLE cycle in which TX is granted.
  - tx_data is captured into PWDATA.
  - PADDR=THR_ADDR, PWRITE=1.
- RX grant:
  - PADDR=RBR_ADDR, PWRITE=0, PWDATA=0.
- IDLE->SETUP on grant. SETUP->ACCESS unconditionally. ACCESS->IDLE when PREADY=1; the FSM stays in ACCESS while PREADY=0.
- Completion (ACCESS & PREADY):
  - PSLVERR=0:
    - The channel counter decrements by one.
    - For RX, PRDATA is loaded into rx_data and rx_valid is set.
  - PSLVERR=1:
    - The channel's err flag is set and its busy flag clears, which aborts the transfer. No done pulse is issued.
    - An RX byte read with an error is discarded.
- When the counter reaches 0 after a completion, busy clears and done pulses for one cycle.
- rx_valid clears on rx_valid & rx_ready.
- start handling:
  - start while the channel is busy is ignored.
  - start with len=0 produces a done pulse the next cycle and busy never asserts.
- A start that arrives while the other channel owns the bus is accepted; the new channel competes at the next IDLE.
- err_clr takes precedence over a simultaneous error set.

## Timing
- Reset values: PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0. tx_ready=0, rx_valid=0, rx_data=0. busy, done and err flags all 0. FSM=IDLE. Counters=0.
- Reset asserted mid-transfer returns the block to IDLE immediately. PSEL drops asynchronously. A partial byte is lost.
- PSEL is high in SETUP and ACCESS. PENABLE is high only in ACCESS.
- PADDR, PWRITE and PWDATA are registered and stable from SETUP through the end of ACCESS.
- Zero-wait transfer:
  - IDLE (grant), SETUP, ACCESS: 3 cycles per byte, with a mandatory IDLE between transfers.
  - Each PREADY=0 cycle adds one cycle.
- Output timing after ACCESS & PREADY at cycle n:
  - rx_valid is high at n+1.
  - busy clears and done is high at n+1.
- TXDRDYn and RXDRDYn are used as already synchronous to PCLK. They are ignored outside IDLE.

## Test plan
- TX burst: tx_len=3 with bytes 8'hA5, 8'h5A, 8'h3C, TXDRDYn=0, PREADY=1 -> three APB writes to THR_ADDR, 3 cycles each, in order. tx_done pulses once, one cycle after the third ACCESS. tx_busy returns to 0.
- RX with backpressure: rx_len=2, RXDRDYn=0, PRDATA=8'h11 then 8'h22, rx_ready held low 5 cycles -> the second read is not issued until the first byte is accepted. rx_data delivers 8'h11 then 8'h22. rx_done pulses once.
- Arbitration: both channels started with len=2 and both always eligible -> grant order TX, RX, TX, RX.
- Wait states: PREADY low for 4 cycles in the first ACCESS -> PSEL, PENABLE, PADDR and PWDATA are held constant. The transfer takes 7 cycles. Counter decrements once.
- Error: PSLVERR=1 on the second of 4 TX writes -> tx_err=1, tx_busy=0, no tx_done, no further writes. err_clr then sets tx_err=0.
- Boundary: rx_start with rx_len=0 -> rx_done pulse next cycle with no APB activity. PRESETn asserted during ACCESS -> all outputs return to their reset values immediately.
